bus_apb_bridge: RTL
===================

# bus_apb_bridge

Multi-slave bridge from the team's simple `bus_*` request/response port to an APB4 requester with NUM_SLAVES select lines. It accepts one transfer at a time from a bus master and decodes the address to one APB completer. It runs the APB SETUP/ACCESS sequence, stretches for wait states, and returns read data and error status with a one-cycle `bus_ready` pulse. A programmable timeout turns a hung completer into `bus_slverr` instead of a bus lock-up.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width; multiple of 8
- NUM_SLAVES, 4, number of APB completers, 1..16
- SLV_BASE, 0, packed NUM_SLAVES*ADDR_WIDTH base addresses; slot i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- SLV_MASK, 0, packed mask per slot, same layout; a slot matches when (addr & mask) == (base & mask)
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout

Ports:
- Clock and reset (already decided): one clock, `clk`; reset `rst_n`, asynchronous, active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- bus_ena  in  1  transfer request; held high by the master until `bus_ready`
- bus_wstb  in  DATA_WIDTH/8  write byte strobes; all-zero means read
- bus_addr  in  ADDR_WIDTH  byte address
- bus_wdata  in  DATA_WIDTH  write data
- bus_ready  out  1  one-cycle completion pulse
- bus_rdata  out  DATA_WIDTH  read data; valid while `bus_ready`=1
- bus_slverr  out  1  error flag; valid while `bus_ready`=1
- paddr  out  ADDR_WIDTH  APB address
- psel  out  NUM_SLAVES  one-hot completer select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB write strobes
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-completer read data, packed like SLV_BASE
- pready  in  NUM_SLAVES  per-completer ready
- pslverr  in  NUM_SLAVES  per-completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE: if `bus_ena`=1, capture addr, wdata and wstb, then decode.
  - Decode hit: the lowest matching index wins → SETUP.
  - No hit → DONE with error (no APB cycle).
- SETUP: psel[sel]=1, penable=0, paddr/pwrite/pwdata/pstrb driven from the captured request → ACCESS next cycle.
- ACCESS: penable=1. Sample pready[sel], prdata[sel] and pslverr[sel].
  - pready[sel]=1: capture rdata (reads only, else 0) and slverr → DONE.
  - Timeout: if TIMEOUT_CYCLES≠0 and the wait counter reaches TIMEOUT_CYCLES with pready still 0, drop psel/penable, slverr=1, rdata=0 → DONE.
- DONE: bus_ready=1 for exactly one cycle, psel=0, penable=0 → IDLE. `bus_ena` is ignored in DONE.
- pwrite = |wstb. pstrb = wstb on writes, 0 on reads. pwdata = 0 on reads.
- bus_rdata and bus_slverr hold their last value outside DONE.
- Inputs from non-selected completers are ignored.

## Timing
- Reset values: bus_ready=0, bus_rdata=0, bus_slverr=0, paddr=0, psel=0, penable=0, pwrite=0, pwdata=0, pstrb=0, state=IDLE, wait counter=0.
- Zero-wait APB transfer: bus_ena sampled at edge n → SETUP at n+1, ACCESS at n+2, bus_ready high in the cycle after edge n+3. Latency is 3 edges.
- Each cycle pready is held low adds one cycle.
- Unmapped address: bus_ready with slverr=1 one edge after acceptance.
- Timeout: the counter starts at 0 on ACCESS entry and increments each ACCESS cycle. Abort happens on the edge where counter == TIMEOUT_CYCLES-1 and pready=0. Total ACCESS time is exactly TIMEOUT_CYCLES cycles.
- pready and the timeout in the same cycle: pready wins, normal completion.
- Back-to-back transfers: the earliest next acceptance is at the IDLE edge immediately after DONE. There is no idle gap requirement on the master.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronously); the in-flight transfer is dropped with no bus_ready.
- Counter width: $clog2(TIMEOUT_CYCLES+1). No wrap is possible.

## Structure
- Package `bus_apb_pkg` holds:
  - the state enum typedef (`bus_apb_state_e`);
  - a `localparam` helper for the strobe width.
- Sub-module `bus_apb_decoder`: combinational, parameters NUM_SLAVES/ADDR_WIDTH/SLV_BASE/SLV_MASK.
  - Input: address.
  - Outputs: one-hot select and `hit`; priority to the lowest index.
- The top level holds the FSM, capture registers, timeout counter and read mux.

## Test plan
- Write, NUM_SLAVES=4, slot 2 at base 0x2000 mask 0xF000: addr 0x2010, wstb 0xF, wdata 0xDEADBEEF, pready[2]=1 immediately.
  - Required: psel=0b0100, pwrite=1, pstrb=0xF, pwdata=0xDEADBEEF.
  - bus_ready 3 edges after acceptance, slverr=0.
- Read slot 1 with 5 wait states, prdata[1]=0x12345678.
  - Required: penable high for 6 cycles; bus_rdata=0x12345678 during bus_ready; pstrb=0, pwdata=0.
- Unmapped address 0xF000_0000.
  - Required: psel stays 0; bus_ready one edge after acceptance with bus_slverr=1, bus_rdata=0.
- TIMEOUT_CYCLES=8, completer never ready.
  - Required: penable high exactly 8 cycles, then psel/penable drop; bus_ready with slverr=1.
  - Repeat with pready asserted in the 8th cycle → normal completion, slverr=0.
- pslverr[0]=1 with pready on a slot-0 write → bus_slverr=1.
  - Follow immediately with a back-to-back read to slot 3 → accepted at the edge after DONE, completes correctly.
- rst_n pulsed low during ACCESS.
  - Required: psel/penable/bus_ready go to 0 asynchronously; no bus_ready pulse.
  - After release, the next transfer completes normally.

Source files
------------

// File: rtl/bus_apb_pkg.sv
// Shared types for the bus_* to APB4 bridge: FSM state encoding and strobe sizing.
package bus_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } bus_apb_state_e;

   localparam int BITS_PER_BYTE = 8;

   function automatic int strb_width(input int data_width);
      return data_width / BITS_PER_BYTE;
   endfunction

endpackage

// File: rtl/bus_apb_decoder.sv
// Address decoder: base/mask match per completer slot, lowest matching index wins.
module bus_apb_decoder #(
   parameter int                              NUM_SLAVES = 4,
   parameter int                              ADDR_WIDTH = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE  = '0,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK  = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  hit
);

   // Scan from the top down so the lowest matching slot overwrites any higher one.
   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
             (SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            sel    = '0;
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_apb_bridge.sv
// Single-outstanding bridge from the bus_* request port to a multi-completer APB4 requester.
//
//   state  | meaning
//   IDLE   | waiting for bus_ena; decode and capture the request
//   SETUP  | psel asserted, penable low
//   ACCESS | penable high, waiting on pready of the selected completer or timeout
//   DONE   | bus_ready pulse with rdata/slverr, APB released
module bus_apb_bridge
   import bus_apb_pkg::*;
#(
   parameter int                              ADDR_WIDTH     = 32,
   parameter int                              DATA_WIDTH     = 32,
   parameter int                              NUM_SLAVES     = 4,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE      = '0,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK      = '0,
   parameter int                              TIMEOUT_CYCLES = 256
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             bus_ena,
   input  logic [strb_width(DATA_WIDTH)-1:0] bus_wstb,
   input  logic [ADDR_WIDTH-1:0]            bus_addr,
   input  logic [DATA_WIDTH-1:0]            bus_wdata,
   output logic                             bus_ready,
   output logic [DATA_WIDTH-1:0]            bus_rdata,
   output logic                             bus_slverr,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic [NUM_SLAVES-1:0]            psel,
   output logic                             penable,
   output logic                             pwrite,
   output logic [DATA_WIDTH-1:0]            pwdata,
   output logic [strb_width(DATA_WIDTH)-1:0] pstrb,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]            pready,
   input  logic [NUM_SLAVES-1:0]            pslverr
);

   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   bus_apb_state_e          state;
   logic [CNT_W-1:0]        wait_cnt;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_hit;
   logic                    sel_ready;
   logic                    sel_err;
   logic [DATA_WIDTH-1:0]   sel_rdata;

   bus_apb_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_WIDTH (ADDR_WIDTH),
      .SLV_BASE   (SLV_BASE),
      .SLV_MASK   (SLV_MASK)
   ) u_decoder (
      .addr (bus_addr),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

   // psel is one-hot while SETUP/ACCESS, so it doubles as the response mux select.
   assign sel_ready = |(pready & psel);
   assign sel_err   = |(pslverr & psel);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (psel[i]) begin
            sel_rdata = sel_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         bus_ready  <= 1'b0;
         bus_rdata  <= '0;
         bus_slverr <= 1'b0;
         paddr      <= '0;
         psel       <= '0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         pwdata     <= '0;
         pstrb      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus_ena) begin
                  if (dec_hit) begin
                     state  <= ST_SETUP;
                     psel   <= dec_sel;
                     paddr  <= bus_addr;
                     pwrite <= |bus_wstb;
                     pwdata <= (|bus_wstb) ? bus_wdata : '0;
                     pstrb  <= bus_wstb;
                  end else begin
                     state      <= ST_DONE;
                     bus_ready  <= 1'b1;
                     bus_rdata  <= '0;
                     bus_slverr <= 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               state    <= ST_ACCESS;
               penable  <= 1'b1;
               wait_cnt <= '0;
            end
            ST_ACCESS: begin
               if (sel_ready) begin
                  state      <= ST_DONE;
                  psel       <= '0;
                  penable    <= 1'b0;
                  bus_ready  <= 1'b1;
                  bus_rdata  <= pwrite ? '0 : sel_rdata;
                  bus_slverr <= sel_err;
               end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
                  state      <= ST_DONE;
                  psel       <= '0;
                  penable    <= 1'b0;
                  bus_ready  <= 1'b1;
                  bus_rdata  <= '0;
                  bus_slverr <= 1'b1;
               end else if (TIMEOUT_EN) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               bus_ready <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
